// File: rtl/sa_feed_if.sv
// Handshake and operand bus between a job source and the systolic-array feed controller.
// The master side supplies jobs and operands. The slave side (sa_feed_ctrl) drives the array edges.
interface sa_feed_if #(
    parameter int N  = 2,
    parameter int DW = 8
);
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [N*DW-1:0] a_row;
    logic [N*DW-1:0] b_col;
    logic            pe_rst;
    logic            res_valid;
    logic            busy;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, a_row, b_col, pe_rst, res_valid, busy
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, a_row, b_col, pe_rst, res_valid, busy
    );
endinterface

// File: rtl/sa_feed_ctrl.sv
// Loads A and B (row-major, 2*N*N beats) and clears the PEs, then skews the operands into an N x N array for 3N-1 cycles.
// Latency is start + 2*N*N beats + 3N+1 cycles. in_ready is high only in LOAD, and in_valid gaps stall the load.
module sa_feed_ctrl #(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic     clk,
    input  logic     rst,
    sa_feed_if.slave bus
);
    localparam int NN = N * N;
    localparam int CW = $clog2(2 * NN);
    localparam int TW = $clog2(3 * N - 1);
    localparam int IW = $clog2(NN);

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   t, t_nxt;
    logic [DW-1:0]   a_buf [NN];
    logic [DW-1:0]   b_buf [NN];
    logic            beat, last_beat;
    logic [N*DW-1:0] a_nxt, b_nxt;

    assign beat      = bus.in_valid && bus.in_ready;
    assign last_beat = beat && (cnt == CW'(2 * NN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        t_nxt     = '0;
        case (state)
            IDLE:  if (bus.start) state_nxt = LOAD;
            LOAD:  if (last_beat) state_nxt = CLEAR;
            CLEAR: state_nxt = RUN;
            RUN: begin
                if (t == TW'(3 * N - 2)) state_nxt = DONE;
                else                     t_nxt     = t + TW'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wavefront skew: row i / column j enters i / j cycles late, zero-padded outside the window.
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        if (state_nxt == RUN) begin
            for (int i = 0; i < N; i++) begin
                if (int'(t_nxt) >= i && int'(t_nxt) - i < N) begin
                    a_nxt[i*DW +: DW] = a_buf[IW'(i * N + int'(t_nxt) - i)];
                    b_nxt[i*DW +: DW] = b_buf[IW'((int'(t_nxt) - i) * N + i)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t   <= '0;
            cnt <= '0;
            for (int k = 0; k < NN; k++) begin
                a_buf[k] <= '0;
                b_buf[k] <= '0;
            end
        end else begin
            t <= t_nxt;
            if (beat) begin
                cnt <= last_beat ? '0 : cnt + CW'(1);
                if (cnt < CW'(NN)) a_buf[IW'(cnt)]           <= bus.in_data;
                else               b_buf[IW'(cnt - CW'(NN))] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.in_ready  <= 1'b0;
            bus.a_row     <= '0;
            bus.b_col     <= '0;
            bus.pe_rst    <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.in_ready  <= (state_nxt == LOAD);
            bus.a_row     <= a_nxt;
            bus.b_col     <= b_nxt;
            bus.pe_rst    <= (state_nxt == CLEAR);
            bus.res_valid <= (state_nxt == DONE);
            bus.busy      <= (state_nxt != IDLE);
        end
    end
endmodule

// File: doc/sa_feed_ctrl.md
SA_FEED_CTRL -- requirements
Module: sa_feed_ctrl

Interface
REQ-001 Parameter N, default 2, array dimension (N x N processing elements), legal range 2..8.
REQ-002 Parameter DW, default 8, operand width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a matrix job; honoured only in IDLE.
REQ-006 in_valid  input  1  operand word on in_data is valid.
REQ-007 in_ready  output  1  controller accepts in_data this cycle.
REQ-008 in_data  input  DW  operand word.
REQ-009 a_row  output  N*DW  west-edge operands; row i at bits [i*DW +: DW].
REQ-010 b_col  output  N*DW  north-edge operands; column j at bits [j*DW +: DW].
REQ-011 pe_rst  output  1  clear pulse to all PE rst inputs.
REQ-012 res_valid  output  1  one-cycle strobe: PE outputs hold final results.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States IDLE, LOAD, CLEAR, RUN, DONE; all outputs registered.
REQ-015 IDLE: start=1 -> LOAD next cycle; otherwise stay.
REQ-016 LOAD: in_ready=1; a beat is in_valid&&in_ready; beats 0..N*N-1 fill A row-major, beats N*N..2*N*N-1 fill B row-major; in_valid=0 stalls without penalty.
REQ-017 Cycle after the last LOAD beat -> CLEAR; CLEAR lasts exactly 1 cycle with pe_rst=1, then -> RUN.
REQ-018 RUN: counter t runs 0..3N-2 (3N-1 cycles), then -> DONE.
REQ-019 In RUN, a_row[i] = A[i][t-i] when 0 <= t-i <= N-1, else 0.
REQ-020 In RUN, b_col[j] = B[t-j][j] when 0 <= t-j <= N-1, else 0.
REQ-021 Outside RUN, a_row and b_col are 0.
REQ-022 DONE: res_valid=1 for exactly 1 cycle, then -> IDLE.
REQ-023 start outside IDLE is ignored; in_valid outside LOAD is ignored (in_ready=0, no buffer write).
REQ-024 Start-to-res_valid latency with no stalls: 1 (IDLE->LOAD) + 2*N*N beats + 1 CLEAR + (3N-1) RUN cycles; N=2: 15 cycles after the start edge.
REQ-025 Operand buffers are DW-bit, unsigned, stored unmodified; no arithmetic in this block.

Reset
REQ-026 rst=1 forces immediately, regardless of clock: state IDLE, t=0, beat count 0, buffers 0, in_ready=0, a_row=0, b_col=0, pe_rst=1, res_valid=0, busy=0.
REQ-027 pe_rst follows rst (held high while rst=1); the first clock edge after rst drops returns it to 0.
REQ-028 rst in any state, including mid-LOAD or mid-RUN, aborts the job; no res_valid is issued for it.

Verification
REQ-029 rst pulse at time 0 -> all outputs at REQ-026 values before the first clk edge; busy=0, in_ready=0.
REQ-030 N=2, start, stream 1,2,3,4,5,6,7,8 without gaps -> CLEAR pe_rst pulse; RUN t0: a_row={0,1}, b_col={0,5}; t1: a_row={3,2}, b_col={6,7}; t2: a_row={4,0}, b_col={8,0}; t3,t4: all 0; res_valid 15 cycles after start.
REQ-031 Same job with in_valid low for 3 cycles after beat 2 -> identical RUN pattern; res_valid 18 cycles after start.
REQ-032 start asserted during LOAD and again during RUN -> no effect; exactly one res_valid; no second job begins.
REQ-033 rst asserted at RUN t=1 -> immediate return to IDLE with a_row=b_col=0, no res_valid; subsequent job with A=13,1,11,3 and B=1,3,13,11 runs correctly.
REQ-034 in_valid=1 in IDLE with data 0xFF, then normal job -> 0xFF not captured; RUN pattern matches the loaded job only.
